// File: rtl/Skeleton_package.sv
// System address-map constants and shared types for the test RAM slave.
package Skeleton_package;

    localparam int unsigned NUM_MASTERS     = 2;
    localparam int unsigned NUM_SLAVES      = 4;
    localparam int unsigned TEST_RAM_OFFSET = 4096;
    localparam int unsigned TEST_RAM_SIZE   = 256;
    localparam int unsigned TEST_RAM_AW     = $clog2(TEST_RAM_SIZE);

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA} ram_slv_state_t;

endpackage

// File: rtl/test_ram_mem.sv
// Single-port synchronous RAM with a one-cycle read.
// Write-first: a write also returns the new word on rdata.
module test_ram_mem #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/test_ram_slave.sv
// Bus slave for the test RAM window: address decode, read/write handshake FSM
// and a saturating counter of rejected cycles.
module test_ram_slave
    import Skeleton_package::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned BASE   = TEST_RAM_OFFSET,
    parameter int unsigned DEPTH  = TEST_RAM_SIZE
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] Address,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] WriteData,
    output logic              WaitRequest,
    output logic [DATA_W-1:0] ReadData,
    output logic              ReadDataValid,
    output logic              Hit,
    output logic [7:0]        ErrCount
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra bit so BASE+DEPTH cannot wrap at the top of the map.
    localparam logic [ADDR_W:0] WinLo = (ADDR_W + 1)'(BASE);
    localparam logic [ADDR_W:0] WinHi = (ADDR_W + 1)'(BASE + DEPTH);

    ram_slv_state_t    state_q, state_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rdv_q;
    logic [7:0]        err_q;

    logic [ADDR_W:0]   addr_ext;
    logic [AW-1:0]     local_addr;
    logic              idle_req, rd_ok, wr_ok, bad_req;
    logic              mem_en, mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign addr_ext   = {1'b0, Address};
    assign Hit        = (addr_ext >= WinLo) && (addr_ext < WinHi);
    assign local_addr = Address[AW-1:0];

    assign idle_req = (state_q == IDLE) && (Read || Write) && !Reset;
    assign rd_ok    = idle_req && Read && !Write && Hit;
    assign wr_ok    = idle_req && Write && !Read && Hit;
    assign bad_req  = idle_req && (!Hit || (Read && Write));

    always_comb begin
        state_d     = state_q;
        WaitRequest = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_ok) begin
                    state_d     = RD_ADDR;
                    WaitRequest = 1'b1;
                    mem_en      = 1'b1;
                end else if (wr_ok) begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                end
            end
            RD_ADDR: begin
                WaitRequest = 1'b1;
                state_d     = RD_DATA;
            end
            RD_DATA: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            rdv_q   <= (state_q == RD_ADDR);
            if (state_q == RD_ADDR) begin
                rdata_q <= mem_rdata;
            end
            if (bad_req && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign ReadData      = rdata_q;
    assign ReadDataValid = rdv_q;
    assign ErrCount      = err_q;

    test_ram_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (Clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (local_addr),
        .wdata (WriteData),
        .rdata (mem_rdata)
    );

endmodule
